// File: rtl/ext_mem_slave_2ch.sv
// ext_mem_slave_2ch: byte-wide two-channel memory responder with
// fixed read/write latency, side preload port and sticky bus error.
module ext_mem_slave_2ch #(
    parameter int MEMSIZE     = 64,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  base_addr,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [15:0] Mout_addr_ram,
    input  logic [15:0] Mout_Wdata_ram,
    input  logic [7:0]  Mout_data_ram_size,
    output logic [15:0] M_Rdata_ram,
    output logic [1:0]  M_DataRdy,
    output logic        bus_error
);

    localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int CW = 8;
    localparam logic [CW-1:0] RD_LAST = CW'(READ_DELAY - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WRITE_DELAY - 1);
    localparam logic [8:0] MSZ = 9'(MEMSIZE);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

    logic [7:0]    mem_q [MEMSIZE];
    state_e        state_q [2];
    state_e        state_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [15:0]   rdata_q;
    logic [15:0]   rdata_d;
    logic          bus_error_q;
    logic          bus_error_d;

    logic [1:0]    hit;
    logic [AW-1:0] off [2];
    logic [7:0]    rbyte [2];
    logic [7:0]    wbyte [2];
    logic [1:0]    rdy;
    logic [1:0]    wr_go;
    logic [1:0]    err_set;
    logic [1:0]    wr_commit;
    logic          ld_ok;
    logic          ld_commit;
    logic [AW-1:0] ld_off;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [8:0] a9;
        logic [8:0] lo9;
        logic [3:0] sz;
        logic [7:0] mask;

        assign a9     = {1'b0, Mout_addr_ram[8*c +: 8]};
        assign lo9    = {1'b0, base_addr};
        assign hit[c] = (a9 >= lo9) && (a9 < (lo9 + MSZ));
        assign off[c] = AW'(a9 - lo9);
        assign sz     = Mout_data_ram_size[4*c +: 4];
        assign mask   = sz[3] ? 8'hFF : 8'((9'd1 << sz[2:0]) - 9'd1);
        assign rbyte[c] = mem_q[off[c]];
        assign wbyte[c] = (Mout_Wdata_ram[8*c +: 8] & mask)
                        | (rbyte[c] & ~mask);
        assign rdata_d[8*c +: 8] = (Mout_oe_ram[c] && hit[c]) ? rbyte[c] : 8'h00;
        assign wr_commit[c] = wr_go[c] & reset;
    end

    assign ld_ok     = load_en && ({1'b0, load_addr} < MSZ);
    assign ld_commit = ld_ok & reset;
    assign ld_off    = AW'(load_addr);

    // Per-channel access sequencing: counts held cycles, flags errors
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            rdy[c]     = 1'b0;
            wr_go[c]   = 1'b0;
            err_set[c] = 1'b0;
            if ((Mout_oe_ram[c] && Mout_we_ram[c])
                || (state_q[c] == RD_WAIT && Mout_we_ram[c])
                || (state_q[c] == WR_WAIT && Mout_oe_ram[c])) begin
                err_set[c] = 1'b1;
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
            end else if (Mout_oe_ram[c] && hit[c]) begin
                if (cnt_q[c] == RD_LAST) begin
                    rdy[c]     = 1'b1;
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end else begin
                    state_d[c] = RD_WAIT;
                    cnt_d[c]   = cnt_q[c] + 1'b1;
                end
            end else if (Mout_we_ram[c] && hit[c]) begin
                if (cnt_q[c] == WR_LAST) begin
                    rdy[c]     = 1'b1;
                    wr_go[c]   = 1'b1;
                    state_d[c] = IDLE;
                    cnt_d[c]   = '0;
                end else begin
                    state_d[c] = WR_WAIT;
                    cnt_d[c]   = cnt_q[c] + 1'b1;
                end
            end else begin
                state_d[c] = IDLE;
                cnt_d[c]   = '0;
            end
        end
        bus_error_d = bus_error_q | (|err_set);
    end

    // Channel state, read lanes and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            rdata_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Storage is never cleared; later assignments win on same-byte conflicts
    always_ff @(posedge clock) begin
        if (wr_commit[0]) mem_q[off[0]] <= wbyte[0];
        if (wr_commit[1]) mem_q[off[1]] <= wbyte[1];
        if (ld_commit)    mem_q[ld_off] <= load_data;
    end

    assign M_DataRdy   = rdy & {2{reset}};
    assign M_Rdata_ram = rdata_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_ext_mem_slave_2ch.sv
// tb_ext_mem_slave_2ch: randomized scoreboard bench for the
// two-channel memory responder against an array reference model.
module tb_ext_mem_slave_2ch;

    localparam int RD   = 2;
    localparam int WR   = 1;
    localparam int MSZ  = 64;
    localparam int BASE = 'h10;

    typedef struct {
        bit         rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  base_addr = 8'(BASE);
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic [1:0]  Mout_oe_ram = '0;
    logic [1:0]  Mout_we_ram = '0;
    logic [15:0] Mout_addr_ram = '0;
    logic [15:0] Mout_Wdata_ram = '0;
    logic [7:0]  Mout_data_ram_size = '0;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic        bus_error;

    ext_mem_slave_2ch #(
        .MEMSIZE(MSZ), .READ_DELAY(RD), .WRITE_DELAY(WR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .base_addr(base_addr),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .Mout_oe_ram(Mout_oe_ram),
        .Mout_we_ram(Mout_we_ram),
        .Mout_addr_ram(Mout_addr_ram),
        .Mout_Wdata_ram(Mout_Wdata_ram),
        .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram),
        .M_DataRdy(M_DataRdy),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    logic [7:0] mem_m [MSZ];

    int         op_r [2];
    logic [7:0] ad_r [2];
    logic [7:0] wd_r [2];
    logic [3:0] sz_r [2];
    bit         ld_r;
    logic [7:0] lda_r;
    logic [7:0] ldd_r;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h",
                     nm, cyc, act, req);
        end
    endtask

    function automatic bit hitf(input logic [7:0] a);
        return int'(a) >= BASE && int'(a) < BASE + MSZ;
    endfunction

    function automatic logic [7:0] merge(input logic [7:0] wd,
                                         input logic [3:0] sz,
                                         input logic [7:0] old);
        int m;
        m = (sz >= 8) ? 255 : (1 << sz) - 1;
        return (wd & 8'(m)) | (old & ~8'(m));
    endfunction

    // Monitor: every completion strobe must match the oldest expectation
    always @(negedge clock) begin : mon
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (M_DataRdy[c] === 1'b1) begin
                if ((c == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy ch%0d @cycle %0d: got 1, required 0",
                             c, cyc);
                end else begin
                    if (c == 0) e = sbq0.pop_front();
                    else e = sbq1.pop_front();
                    chk($sformatf("rdy_cycle_ch%0d", c), cyc, e.cyc);
                    if (e.rd)
                        chk($sformatf("rdata_ch%0d", c),
                            M_Rdata_ram[8*c +: 8], e.data);
                end
            end
        end
    end

    task automatic setop(input int c, input int op, input int a,
                         input int wd, input int sz);
        op_r[c] = op;
        ad_r[c] = 8'(a);
        wd_r[c] = 8'(wd);
        sz_r[c] = 4'(sz);
    endtask

    // Issue both channels together; each holds for its own latency
    task automatic run_pair();
        int d [2];
        int dmax;
        bit h [2];
        int off [2];
        logic [7:0] nv [2];
        logic [7:0] v;
        exp_t e;
        dmax = 1;
        for (int c = 0; c < 2; c++) begin
            h[c]   = (op_r[c] != 0) && hitf(ad_r[c]);
            off[c] = int'(ad_r[c]) - BASE;
            d[c]   = (op_r[c] == 1) ? RD : (op_r[c] == 2) ? WR : 0;
            if (d[c] > dmax) dmax = d[c];
            nv[c]  = h[c] ? merge(wd_r[c], sz_r[c], mem_m[off[c]]) : 8'h00;
        end
        for (int c = 0; c < 2; c++) begin
            if (h[c]) begin
                v = 8'h00;
                if (op_r[c] == 1) begin
                    v = mem_m[off[c]];
                    if (WR - 1 < RD - 2)
                        for (int w = 0; w < 2; w++)
                            if (op_r[w] == 2 && h[w] && off[w] == off[c])
                                v = nv[w];
                    if (RD > 2 && ld_r && int'(lda_r) == off[c])
                        v = ldd_r;
                end
                e.rd = (op_r[c] == 1);
                e.data = v;
                e.cyc = cyc + d[c] - 1;
                if (c == 0) sbq0.push_back(e);
                else sbq1.push_back(e);
            end
            Mout_oe_ram[c] = (op_r[c] == 1);
            Mout_we_ram[c] = (op_r[c] == 2);
            Mout_addr_ram[8*c +: 8] = ad_r[c];
            Mout_Wdata_ram[8*c +: 8] = wd_r[c];
            Mout_data_ram_size[4*c +: 4] = sz_r[c];
        end
        load_en   = ld_r;
        load_addr = lda_r;
        load_data = ldd_r;
        for (int t = 1; t <= dmax; t++) begin
            @(posedge clock);
            #1;
            if (t == 1) begin
                load_en = 1'b0;
                for (int c = 0; c < 2; c++)
                    if (op_r[c] == 1 && !h[c])
                        chk($sformatf("miss_lane_ch%0d", c),
                            M_Rdata_ram[8*c +: 8], 8'h00);
            end
            for (int c = 0; c < 2; c++)
                if (t == d[c]) begin
                    Mout_oe_ram[c] = 1'b0;
                    Mout_we_ram[c] = 1'b0;
                end
        end
        Mout_oe_ram = '0;
        Mout_we_ram = '0;
        for (int c = 0; c < 2; c++)
            if (op_r[c] == 2 && h[c]) mem_m[off[c]] = nv[c];
        if (ld_r && int'(lda_r) < MSZ) mem_m[lda_r] = ldd_r;
        ld_r = 1'b0;
    endtask

    task automatic idle_ops();
        setop(0, 0, 0, 0, 0);
        setop(1, 0, 0, 0, 0);
        ld_r = 1'b0;
    endtask

    initial begin
        idle_ops();
        lda_r = '0;
        ldd_r = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_rdy", M_DataRdy, 2'b00);
        chk("rst_rdata", M_Rdata_ram, 16'h0);
        chk("rst_berr", bus_error, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i <= MSZ; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = (i < MSZ) ? 8'(i ^ 'hA5) : 8'hEE;
            if (i < MSZ) mem_m[i] = 8'(i ^ 'hA5);
            @(posedge clock);
            #1;
        end
        load_en = 1'b0;

        setop(0, 1, 'h15, 0, 0);
        setop(1, 1, 'h4F, 0, 0);
        run_pair();
        chk("model_0x15", mem_m['h05], 8'hA0);

        idle_ops();
        setop(0, 2, 'h12, 'hFF, 0);
        run_pair();
        setop(0, 1, 'h12, 0, 0);
        run_pair();
        setop(0, 2, 'h12, 'hFF, 4);
        run_pair();
        setop(1, 1, 'h12, 0, 0);
        setop(0, 0, 0, 0, 0);
        run_pair();
        chk("model_0x12", mem_m['h02], 8'hAF);

        setop(0, 2, 'h20, 'h11, 8);
        setop(1, 2, 'h20, 'h22, 8);
        run_pair();
        setop(0, 1, 'h20, 0, 0);
        setop(1, 0, 0, 0, 0);
        run_pair();
        setop(0, 2, 'h20, 'h11, 8);
        setop(1, 2, 'h20, 'h22, 8);
        ld_r = 1'b1;
        lda_r = 8'h10;
        ldd_r = 8'h33;
        run_pair();
        setop(0, 0, 0, 0, 0);
        setop(1, 1, 'h20, 0, 0);
        run_pair();
        chk("model_0x20", mem_m['h10], 8'h33);

        Mout_oe_ram = 2'b11;
        Mout_addr_ram = 16'h500F;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (t > 0) chk("miss_rdata", M_Rdata_ram, 16'h0);
            chk("miss_rdy", M_DataRdy, 2'b00);
        end
        @(posedge clock);
        #1;
        Mout_oe_ram = '0;
        setop(0, 1, 'h10, 0, 0);
        setop(1, 1, 'h4F, 0, 0);
        run_pair();

        Mout_we_ram[0] = 1'b1;
        Mout_addr_ram[7:0] = 8'h30;
        Mout_Wdata_ram[7:0] = 8'h5A;
        Mout_data_ram_size[3:0] = 4'd8;
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_rdy", M_DataRdy, 2'b00);
        chk("rstmid_rdata", M_Rdata_ram, 16'h0);
        chk("rstmid_berr", bus_error, 1'b0);
        @(posedge clock);
        #1;
        Mout_we_ram = '0;
        reset = 1'b1;
        setop(0, 1, 'h30, 0, 0);
        setop(1, 1, 'h15, 0, 0);
        run_pair();
        chk("model_0x30", mem_m['h20], 8'h85);

        Mout_oe_ram[1] = 1'b1;
        Mout_we_ram[1] = 1'b1;
        Mout_addr_ram[15:8] = 8'h20;
        @(negedge clock);
        chk("berr_before", bus_error, 1'b0);
        @(posedge clock);
        #1;
        Mout_oe_ram = '0;
        Mout_we_ram = '0;
        chk("berr_set", bus_error, 1'b1);
        setop(0, 1, 'h11, 0, 0);
        setop(1, 2, 'h40, 'h77, 8);
        run_pair();
        chk("berr_sticky", bus_error, 1'b1);
        reset = 1'b0;
        #1;
        chk("berr_clear", bus_error, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 250; n++) begin
            for (int c = 0; c < 2; c++)
                setop(c, int'($urandom_range(0, 2)),
                      int'($urandom_range('h08, 'h57)),
                      int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 15)));
            ld_r = ($urandom_range(0, 7) == 0);
            lda_r = 8'($urandom_range(0, 70));
            ldd_r = 8'($urandom);
            run_pair();
        end
        idle_ops();
        for (int a = BASE; a < BASE + MSZ; a += 2) begin
            setop(0, 1, a, 0, 0);
            setop(1, 1, a + 1, 0, 0);
            run_pair();
        end
        chk("berr_final", bus_error, 1'b0);

        for (int t = 0; t < 20; t++) begin
            if (sbq0.size() == 0 && sbq1.size() == 0) break;
            @(negedge clock);
        end
        chk("sb_drain", sbq0.size() + sbq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
